// File: rtl/pipelined_rc_adder.sv
// Pipelined ripple-carry adder/subtractor.
// The operands are cut into SEG-bit segments; stage k ripples segment k and
// registers it, while the untouched upper segments of a and b' travel along
// in skew registers. Each stage holds one transaction, so STAGES are in flight.
//
// Handshake: a transfer happens on any rising edge where valid && ready.
// Stage k advances when it is valid and the stage after it is empty or
// advancing; the last stage advances when out_valid && out_ready.
// in_ready = !valid_0 || advance_0, so it depends combinationally on out_ready
// and on stage state, never on in_valid. Empty slots are filled even while
// the head is stalled (bubble collapse), and a stalled last stage holds
// sum/cout/ovf steady.
module pipelined_rc_adder #(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = WIDTH / SEG;

  if ((SEG < 1) || (STAGES < 1) || ((WIDTH % SEG) != 0)) begin : g_param_check
    $error("pipelined_rc_adder: WIDTH must be a non-zero multiple of SEG");
  end

  // Per-stage registers: valid, operands (b already conditioned), partial sum,
  // carry out of the stage's segment and carry into the segment's top bit.
  logic [STAGES-1:0] r_v;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_cm;

  // Inputs seen by each stage's segment adder and what it produces.
  logic [WIDTH-1:0]  w_a_in  [STAGES];
  logic [WIDTH-1:0]  w_b_in  [STAGES];
  logic [WIDTH-1:0]  w_s_in  [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [WIDTH-1:0]  w_s_out [STAGES];
  logic [STAGES-1:0] w_c_out;
  logic [STAGES-1:0] w_cm_out;

  // Flow control.
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_load;
  logic              w_in_ready;

  // Stage 0 takes conditioned port operands; later stages take the skewed copy.
  always_comb begin
    w_a_in[0] = a;
    w_b_in[0] = b ^ {WIDTH{sub}};
    w_s_in[0] = '0;
    w_c_in    = '0;
    w_c_in[0] = cin ^ sub;
    for (int k = 1; k < STAGES; k++) begin
      w_a_in[k] = r_a[k-1];
      w_b_in[k] = r_b[k-1];
      w_s_in[k] = r_s[k-1];
      w_c_in[k] = r_c[k-1];
    end
  end

  // Each stage ripples only its own SEG-bit segment through a full-adder chain.
  always_comb begin
    logic             c_run;
    logic             cm_run;
    logic [WIDTH-1:0] s_run;
    w_c_out  = '0;
    w_cm_out = '0;
    for (int k = 0; k < STAGES; k++) begin
      c_run  = w_c_in[k];
      cm_run = 1'b0;
      s_run  = w_s_in[k];
      for (int i = 0; i < SEG; i++) begin
        if (i == SEG - 1) begin
          cm_run = c_run;
        end
        s_run[k*SEG+i] = w_a_in[k][k*SEG+i] ^ w_b_in[k][k*SEG+i] ^ c_run;
        c_run = (w_a_in[k][k*SEG+i] & w_b_in[k][k*SEG+i]) |
                (c_run & (w_a_in[k][k*SEG+i] ^ w_b_in[k][k*SEG+i]));
      end
      w_s_out[k]  = s_run;
      w_c_out[k]  = c_run;
      w_cm_out[k] = cm_run;
    end
  end

  // Advance is resolved from the head backwards so empty slots absorb stalls.
  always_comb begin
    logic [STAGES-1:0] adv_run;
    logic [STAGES-1:0] load_run;
    logic              rdy_run;
    adv_run             = '0;
    adv_run[STAGES-1]   = r_v[STAGES-1] && out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv_run[k] = r_v[k] && (!r_v[k+1] || adv_run[k+1]);
    end
    rdy_run     = !r_v[0] || adv_run[0];
    load_run    = '0;
    load_run[0] = in_valid && rdy_run;
    for (int k = 1; k < STAGES; k++) begin
      load_run[k] = adv_run[k-1];
    end
    w_adv      = adv_run;
    w_load     = load_run;
    w_in_ready = rdy_run;
  end

  // Stage registers: load when the upstream hands over, else drain or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v  <= '0;
      r_c  <= '0;
      r_cm <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_load[k]) begin
          r_v[k]  <= 1'b1;
          r_a[k]  <= w_a_in[k];
          r_b[k]  <= w_b_in[k];
          r_s[k]  <= w_s_out[k];
          r_c[k]  <= w_c_out[k];
          r_cm[k] <= w_cm_out[k];
        end else if (w_adv[k]) begin
          r_v[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_v[STAGES-1];
  assign sum       = r_s[STAGES-1];
  assign cout      = r_c[STAGES-1];
  assign ovf       = r_cm[STAGES-1] ^ r_c[STAGES-1];

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// Testbench for pipelined_rc_adder: directed and random traffic on a 32/8
// instance plus random sweeps of 8/8, 16/4 and 64/16 instances, all checked
// against an arithmetic reference model through expected-result queues.
module tb_pipelined_rc_adder;

  localparam int W      = 32;
  localparam int SEG    = 8;
  localparam int STAGES = W / SEG;

  // ---------------- clock / reset / signals ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         in_valid, in_ready, cin, sub;
  logic [W-1:0] a, b, sum;
  logic         out_valid, out_ready, cout, ovf;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int idx;
  int lat;
  bit rand_ready_en = 1'b0;

  logic [W+1:0]  exp_q [$];
  int            pop_cyc [$];
  logic [63:0]   ra, rb;
  logic [W-1:0]  bp_a [10];
  logic [W-1:0]  bp_b [10];
  logic          bp_c [10];
  logic          bp_s [10];

  always @(posedge clk) cyc <= cyc + 1;

  pipelined_rc_adder #(.WIDTH(W), .SEG(SEG)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  // ---------------- reference model ----------------
  // Returns {ovf, cout, sum}: plain integer arithmetic on w-bit operands.
  // cout is the unsigned carry (add) or "no borrow" (subtract); ovf says the
  // exact signed result does not fit in w bits.
  function automatic logic [65:0] ref_model(input logic [63:0] ta, input logic [63:0] tbv,
                                            input logic tc, input logic ts, input int w);
    logic [65:0]        pw, mask, ua, ub, ur, uc;
    logic signed [65:0] sa, sb, sc, sr, smax, smin;
    logic               co, ov;
    pw   = 66'd1 << w;
    mask = pw - 66'd1;
    ua   = {2'b00, ta} & mask;
    ub   = {2'b00, tbv} & mask;
    uc   = {65'd0, tc};
    sc   = tc ? 66'sd1 : 66'sd0;
    sa   = ua[w-1] ? $signed(ua - pw) : $signed(ua);
    sb   = ub[w-1] ? $signed(ub - pw) : $signed(ub);
    if (ts) begin
      ur = ua - ub - uc;
      co = (ua >= ub + uc);
      sr = sa - sb - sc;
    end else begin
      ur = ua + ub + uc;
      co = (ur >= pw);
      sr = sa + sb + sc;
    end
    smax = $signed(pw >> 1) - 66'sd1;
    smin = -$signed(pw >> 1);
    ov   = (sr > smax) || (sr < smin);
    return {ov, co, ur[63:0] & mask[63:0]};
  endfunction

  function automatic logic [63:0] rand_op(input int w);
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 64'd1 << (w - 1);
      3:       return (64'd1 << (w - 1)) - 64'd1;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [65:0] got, input logic [65:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  task automatic push_exp(input logic [W-1:0] ta, input logic [W-1:0] tbv,
                          input logic tc, input logic ts);
    logic [65:0] r;
    r = ref_model({32'd0, ta}, {32'd0, tbv}, tc, ts, W);
    exp_q.push_back({r[65], r[64], r[W-1:0]});
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a rising edge. Holds the operands valid until accepted;
  // acceptance is decided at the falling edge, where in_ready is settled.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                      input logic ts, input bit use_k, input logic [W+1:0] k);
    bit ok;
    a = ta; b = tbv; cin = tc; sub = ts;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      if (in_ready) begin
        if (use_k) exp_q.push_back(k);
        else       push_exp(ta, tbv, tc, ts);
        ok = 1'b1;
      end
      @(posedge clk); #1;
      if (rand_ready_en) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    if (!ok) fail_now("send_accept");
  endtask

  task automatic measure_latency(output int l);
    l = 0;
    while (!out_valid && l < 50) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 300 && (exp_q.size() != 0 || out_valid); t++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", 66'(exp_q.size()), 66'd0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && out_valid) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_output");
        end else if (out_ready) begin
          check("result", 66'({ovf, cout, sum}), 66'(exp_q.pop_front()));
          pop_cyc.push_back(cyc);
        end else begin
          check("stall_hold", 66'({ovf, cout, sum}), 66'(exp_q[0]));
        end
      end
    end
  end

  // ---------------- main stimulus ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_out_valid", 66'(out_valid), 66'd0);
    check("reset_outputs", 66'({ovf, cout, sum}), 66'd0);
    @(negedge clk); #2 rst_n = 1'b1;
    #1 check("in_ready_after_reset", 66'(in_ready), 66'd1);
    @(posedge clk); #1;

    // Directed arithmetic with hand-computed results {ovf, cout, sum}.
    send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {2'b00, 32'h0000_0100});
    measure_latency(lat);
    check("latency", 66'(lat), 66'(STAGES - 1));
    send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b1, {1'b0, 1'b1, 32'h0000_0000});
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1'b1, {1'b1, 1'b0, 32'h8000_0000});
    send(32'd5, 32'd7, 1'b0, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFE});
    send(32'd7, 32'd5, 1'b0, 1'b1, 1'b1, {1'b0, 1'b1, 32'h0000_0002});
    send(32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1, {1'b1, 1'b1, 32'h7FFF_FFFF});
    send(32'd0, 32'd0, 1'b1, 1'b1, 1'b1, {1'b0, 1'b0, 32'hFFFF_FFFF});
    send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1, {1'b1, 1'b1, 32'h0000_0000});
    drain();

    // Backpressure: only STAGES transactions fit while the head is stalled.
    for (int i = 0; i < 10; i++) begin
      bp_a[i] = $urandom; bp_b[i] = $urandom;
      bp_c[i] = 1'($urandom_range(0, 1)); bp_s[i] = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b0;
    idx = 0;
    a = bp_a[0]; b = bp_b[0]; cin = bp_c[0]; sub = bp_s[0];
    in_valid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (in_ready && idx < 10) begin
        push_exp(bp_a[idx], bp_b[idx], bp_c[idx], bp_s[idx]);
        idx++;
      end
      @(posedge clk); #1;
      if (idx < 10) begin
        a = bp_a[idx]; b = bp_b[idx]; cin = bp_c[idx]; sub = bp_s[idx];
      end
    end
    in_valid = 1'b0;
    check("bp_accepted", 66'(idx), 66'(STAGES));
    check("bp_in_ready_low", 66'(in_ready), 66'd0);
    out_ready = 1'b1;
    for (int i = idx; i < 10; i++) send(bp_a[i], bp_b[i], bp_c[i], bp_s[i], 1'b0, '0);
    drain();

    // Bubbles: valid pattern 1,0,1,0 into a stalled pipe; the gap must close.
    out_ready = 1'b0;
    pop_cyc.delete();
    for (int c = 0; c < 4; c++) begin
      in_valid = (c % 2 == 0);
      a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_valid && in_ready) push_exp(a, b, cin, sub);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    check("bubble_count", 66'(pop_cyc.size()), 66'd2);
    if (pop_cyc.size() == 2) check("bubble_spacing", 66'(pop_cyc[1] - pop_cyc[0]), 66'd1);

    // Reset while three transactions are in flight.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send($urandom, $urandom, 1'b0, 1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_out_valid", 66'(out_valid), 66'd0);
    check("midreset_outputs", 66'({ovf, cout, sum}), 66'd0);
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #3 rst_n = 1'b1;
    #1 check("midreset_in_ready", 66'(in_ready), 66'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    send($urandom, $urandom, 1'b0, 1'b1, 1'b0, '0);
    measure_latency(lat);
    check("midreset_latency", 66'(lat), 66'(STAGES - 1));
    drain();

    // Random traffic with random gaps and random backpressure.
    rand_ready_en = 1'b1;
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk); #1;
        out_ready = ($urandom_range(0, 3) != 0);
      end
      ra = rand_op(W); rb = rand_op(W);
      send(ra[W-1:0], rb[W-1:0], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, '0);
    end
    rand_ready_en = 1'b0;
    out_ready = 1'b1;
    drain();

    // Wait for the parameter sweep instances.
    for (int t = 0; t < 30000 && !(g_sw[0].done && g_sw[1].done && g_sw[2].done); t++) begin
      @(posedge clk);
    end
    if (!(g_sw[0].done && g_sw[1].done && g_sw[2].done)) fail_now("sweep_finish");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- parameter sweep ----------------
  for (genvar g = 0; g < 3; g++) begin : g_sw
    localparam int SW  = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    localparam int SS  = (g == 0) ? 8 : (g == 1) ? 4  : 16;
    localparam int SST = SW / SS;

    logic          s_rst_n, s_in_valid, s_in_ready, s_cin, s_sub;
    logic          s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [SW-1:0] s_a, s_b, s_sum;
    logic [SW+1:0] q [$];
    bit            done = 1'b0;

    pipelined_rc_adder #(.WIDTH(SW), .SEG(SS)) u_dut (
      .clk       (clk),
      .rst_n     (s_rst_n),
      .in_valid  (s_in_valid),
      .in_ready  (s_in_ready),
      .a         (s_a),
      .b         (s_b),
      .cin       (s_cin),
      .sub       (s_sub),
      .out_valid (s_out_valid),
      .out_ready (s_out_ready),
      .sum       (s_sum),
      .cout      (s_cout),
      .ovf       (s_ovf)
    );

    // Monitor for this instance.
    initial begin
      forever begin
        @(negedge clk);
        if (s_rst_n === 1'b1 && s_out_valid) begin
          if (q.size() == 0) begin
            fail_now($sformatf("sw%0d_unexpected_output", SW));
          end else if (s_out_ready) begin
            check($sformatf("sw%0d_result", SW), 66'({s_ovf, s_cout, s_sum}), 66'(q.pop_front()));
          end else begin
            check($sformatf("sw%0d_stall_hold", SW), 66'({s_ovf, s_cout, s_sum}), 66'(q[0]));
          end
        end
      end
    end

    // Driver for this instance.
    initial begin
      logic [63:0] xa, xb;
      logic [65:0] r;
      int          l;
      bit          acc;
      s_rst_n = 1'b0; s_in_valid = 1'b0; s_a = '0; s_b = '0; s_cin = 1'b0; s_sub = 1'b0;
      s_out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 s_rst_n = 1'b1;
      @(posedge clk); #1;

      // Isolated transaction to measure latency.
      xa = rand_op(SW); xb = rand_op(SW);
      s_a = xa[SW-1:0]; s_b = xb[SW-1:0]; s_cin = 1'b1; s_sub = 1'b0;
      s_in_valid = 1'b1;
      @(negedge clk);
      check($sformatf("sw%0d_in_ready_idle", SW), 66'(s_in_ready), 66'd1);
      if (s_in_ready) begin
        r = ref_model(xa, xb, s_cin, s_sub, SW);
        q.push_back({r[65], r[64], r[SW-1:0]});
      end
      @(posedge clk); #1;
      s_in_valid = 1'b0;
      l = 0;
      while (!s_out_valid && l < 50) begin
        @(posedge clk); #1;
        l++;
      end
      check($sformatf("sw%0d_latency", SW), 66'(l), 66'(SST - 1));

      for (int n = 0; n < 1000; n++) begin
        if ($urandom_range(0, 3) == 0) begin
          s_in_valid = 1'b0;
          @(posedge clk); #1;
          s_out_ready = ($urandom_range(0, 3) != 0);
        end
        xa = rand_op(SW); xb = rand_op(SW);
        s_a = xa[SW-1:0]; s_b = xb[SW-1:0];
        s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
        s_in_valid = 1'b1;
        acc = 1'b0;
        for (int t = 0; t < 100 && !acc; t++) begin
          @(negedge clk);
          if (s_in_ready) begin
            r = ref_model(xa, xb, s_cin, s_sub, SW);
            q.push_back({r[65], r[64], r[SW-1:0]});
            acc = 1'b1;
          end
          @(posedge clk); #1;
          s_out_ready = ($urandom_range(0, 3) != 0);
        end
        if (!acc) fail_now($sformatf("sw%0d_send_accept", SW));
      end
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      for (int t = 0; t < 500 && (q.size() != 0 || s_out_valid); t++) begin
        @(posedge clk); #1;
      end
      check($sformatf("sw%0d_drain_empty", SW), 66'(q.size()), 66'd0);
      done = 1'b1;
    end
  end

endmodule
